// File: rtl/alu_regfile_pipe_if.sv
// Decode-side bus of the execute stage: operation issue, debug read port and writeback results.
// The master drives operations; the slave is the execute datapath.
interface alu_regfile_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
);
    localparam int AW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic             use_imm;
    logic [WIDTH-1:0] imm;
    logic [AW-1:0]    dbg_sel;
    logic [WIDTH-1:0] dbg_data;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [4:0]       flags;

    modport master (
        output in_valid, op, rd, ra, rb, use_imm, imm, dbg_sel,
        input  in_ready, dbg_data, res_valid, res_data, flags
    );

    modport slave (
        input  in_valid, op, rd, ra, rb, use_imm, imm, dbg_sel,
        output in_ready, dbg_data, res_valid, res_data, flags
    );
endinterface

// File: rtl/alu_regfile_pipe.sv
// Two-stage execute datapath: register file with forwarding, single-cycle ALU,
// flags register {N,Z,F,L,C} and a one-bit-per-cycle iterative shifter.
module alu_regfile_pipe #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    alu_regfile_pipe_if.slave   io_bus
);
    // state  | meaning
    // S_IDLE | no operation held in E
    // S_EXEC | E holds an operation; completes when r_cnt reaches 0
    typedef enum logic {S_IDLE, S_EXEC} state_t;

    localparam int AW  = $clog2(NREGS);
    localparam int SW  = $clog2(WIDTH);
    localparam int NR2 = 1 << AW;
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;

    localparam int FN = 4;
    localparam int FZ = 3;
    localparam int FF = 2;
    localparam int FL = 1;
    localparam int FC = 0;

    // Entries at or above NREGS exist only to pad the array to 2**AW; they are never written.
    localparam logic [NR2-1:0] REG_OK = {NR2{1'b1}} >> (NR2 - NREGS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_regs [NR2];
    logic [3:0]       r_op;
    logic [AW-1:0]    r_rd;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [SW-1:0]    r_cnt;
    logic             r_shifted;
    logic             r_sc;
    logic [4:0]       r_flags;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;

    logic             w_ready;
    logic             w_accept;
    logic             w_done;
    logic             w_wr;
    logic             w_we;
    logic             w_pulse;
    logic             w_in_shift;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [4:0]       w_flags_nxt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;

    assign w_ready    = !((r_state == S_EXEC) && (r_cnt != '0));
    assign w_accept   = io_bus.in_valid && w_ready;
    assign w_done     = (r_state == S_EXEC) && (r_cnt == '0);
    assign w_we       = w_done && w_wr && REG_OK[r_rd];
    assign w_in_shift = (io_bus.op == OP_SHL) || (io_bus.op == OP_SHR) || (io_bus.op == OP_ASR);

    // Operands bypass the register file when the completing op writes the register being read.
    assign w_opa = (w_we && (r_rd == io_bus.ra)) ? w_res : r_regs[io_bus.ra];
    assign w_opb = io_bus.use_imm ? io_bus.imm :
                   ((w_we && (r_rd == io_bus.rb)) ? w_res : r_regs[io_bus.rb]);

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b} +
                    {{WIDTH{1'b0}}, (r_op == OP_ADDC) & r_flags[FC]};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_add_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
    assign w_sub_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);

    always_comb begin
        w_res       = '0;
        w_wr        = 1'b0;
        w_pulse     = 1'b0;
        w_flags_nxt = r_flags;
        case (r_op)
            OP_ADD, OP_ADDC: begin
                w_res           = w_sum[WIDTH-1:0];
                w_wr            = 1'b1;
                w_pulse         = 1'b1;
                w_flags_nxt[FC] = w_sum[WIDTH];
                w_flags_nxt[FF] = w_add_ovf;
            end
            OP_SUB, OP_CMP: begin
                w_res           = w_diff[WIDTH-1:0];
                w_wr            = (r_op == OP_SUB);
                w_pulse         = 1'b1;
                w_flags_nxt[FC] = w_diff[WIDTH];
                w_flags_nxt[FF] = w_sub_ovf;
                w_flags_nxt[FL] = w_diff[MSB] ^ w_sub_ovf;
            end
            OP_AND: begin
                w_res   = r_a & r_b;
                w_wr    = 1'b1;
                w_pulse = 1'b1;
            end
            OP_OR: begin
                w_res   = r_a | r_b;
                w_wr    = 1'b1;
                w_pulse = 1'b1;
            end
            OP_XOR: begin
                w_res   = r_a ^ r_b;
                w_wr    = 1'b1;
                w_pulse = 1'b1;
            end
            OP_MOV: begin
                w_res   = r_b;
                w_wr    = 1'b1;
                w_pulse = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ASR: begin
                w_res   = r_a;
                w_wr    = 1'b1;
                w_pulse = 1'b1;
                if (r_shifted) begin
                    w_flags_nxt[FC] = r_sc;
                end
            end
            default: begin
            end
        endcase
        if (w_pulse && (r_op != OP_MOV)) begin
            w_flags_nxt[FZ] = (w_res == '0);
            w_flags_nxt[FN] = w_res[MSB];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC: if (w_done && !w_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NR2; i++) begin
                r_regs[i] <= '0;
            end
            r_op        <= '0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_shifted   <= 1'b0;
            r_sc        <= 1'b0;
            r_flags     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_res_valid <= w_done && w_pulse;
            if (w_done && w_pulse) begin
                r_res_data <= w_res;
                r_flags    <= w_flags_nxt;
            end
            if (w_we) begin
                r_regs[r_rd] <= w_res;
            end
            if (w_accept) begin
                r_op      <= io_bus.op;
                r_rd      <= io_bus.rd;
                r_a       <= w_opa;
                r_b       <= w_opb;
                r_cnt     <= w_in_shift ? w_opb[SW-1:0] : '0;
                r_shifted <= w_in_shift && (w_opb[SW-1:0] != '0);
                r_sc      <= 1'b0;
            end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
                case (r_op)
                    OP_SHL: begin
                        r_a  <= {r_a[MSB-1:0], 1'b0};
                        r_sc <= r_a[MSB];
                    end
                    OP_SHR: begin
                        r_a  <= {1'b0, r_a[MSB:1]};
                        r_sc <= r_a[0];
                    end
                    OP_ASR: begin
                        r_a  <= {r_a[MSB], r_a[MSB:1]};
                        r_sc <= r_a[0];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign io_bus.in_ready  = w_ready;
    assign io_bus.dbg_data  = r_regs[io_bus.dbg_sel];
    assign io_bus.res_valid = r_res_valid;
    assign io_bus.res_data  = r_res_data;
    assign io_bus.flags     = r_flags;

endmodule
